// File: rtl/register_file_nbit_pkg.sv
// rtl/register_file_nbit_pkg.sv - shared defaults and register-index type for the register file
package register_file_nbit_pkg;

    localparam int DEF_WIDTH    = 64;
    localparam int DEF_DEPTH    = 32;
    localparam int DEF_ZERO_REG = 31;
    localparam int DEF_AW       = (DEF_DEPTH > 1) ? $clog2(DEF_DEPTH) : 1;

    typedef logic [DEF_AW-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_entry.sv
// rtl/regfile_entry.sv - one WIDTH-bit register with load enable and asynchronous clear
module regfile_entry #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_file_nbit.sv
// rtl/register_file_nbit.sv - 2-read/1-write register file with write bypass and pending-write scoreboard
module register_file_nbit
    import register_file_nbit_pkg::*;
#(
    parameter  int WIDTH    = DEF_WIDTH,
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int ZERO_REG = DEF_ZERO_REG,
    localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             busy_a,
    output logic             busy_b,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_addr
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] pending;

    logic             wr_ok, issue_ok;
    logic [WIDTH-1:0] stored_a, stored_b;
    logic             pend_a, pend_b;
    logic             hit_a, hit_b, claim_a, claim_b;

    // Out-of-range indices and the hardwired-zero index never touch state.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < (AW+1)'(DEPTH)) && (a != AW'(ZERO_REG));
    endfunction

    assign wr_ok    = wr_en && addr_ok(wr_addr);
    assign issue_ok = issue_en && addr_ok(issue_addr);

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        regfile_entry #(.WIDTH(WIDTH)) u_entry (
            .clk   (clk),
            .reset (reset),
            .load  (wr_ok && (wr_addr == AW'(g))),
            .d     (wr_data),
            .q     (regs[g])
        );
    end

    // A claim issued on the same edge as a writeback wins, so the register stays pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (issue_ok && (issue_addr == AW'(i))) begin
                    pending[i] <= 1'b1;
                end else if (wr_ok && (wr_addr == AW'(i))) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        stored_a = '0;
        stored_b = '0;
        pend_a   = 1'b0;
        pend_b   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i != ZERO_REG) begin
                if (rd_addr_a == AW'(i)) begin
                    stored_a = regs[i];
                    pend_a   = pending[i];
                end
                if (rd_addr_b == AW'(i)) begin
                    stored_b = regs[i];
                    pend_b   = pending[i];
                end
            end
        end
    end

    assign hit_a   = wr_ok && (wr_addr == rd_addr_a);
    assign hit_b   = wr_ok && (wr_addr == rd_addr_b);
    assign claim_a = issue_ok && (issue_addr == rd_addr_a);
    assign claim_b = issue_ok && (issue_addr == rd_addr_b);

    // Bypass is deliberately not gated by reset so in-flight writeback data stays visible.
    assign rd_data_a = hit_a ? wr_data : stored_a;
    assign rd_data_b = hit_b ? wr_data : stored_b;
    assign busy_a    = pend_a && !(hit_a && !claim_a);
    assign busy_b    = pend_b && !(hit_b && !claim_b);

endmodule

// File: tb/tb_register_file_nbit.sv
// tb/tb_register_file_nbit.sv - randomized self-checking bench for register_file_nbit
module tb_register_file_nbit;

    localparam int W  = 64;
    localparam int D  = 32;
    localparam int Z  = 31;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr, issue_addr;
    logic [W-1:0]  rd_data_a, rd_data_b, wr_data;
    logic          busy_a, busy_b, wr_en, issue_en;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mem  [D];
    bit           pend [D];

    always #5 clk = ~clk;

    register_file_nbit dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .busy_a     (busy_a),
        .busy_b     (busy_b),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .issue_en   (issue_en),
        .issue_addr (issue_addr)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_data(input int a);
        if (a == Z) return '0;
        if (wr_en && int'(wr_addr) == a) return wr_data;
        return mem[a];
    endfunction

    function automatic logic exp_busy(input int a);
        if (a == Z) return 1'b0;
        if (wr_en && int'(wr_addr) == a && !(issue_en && int'(issue_addr) == a)) return 1'b0;
        return pend[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < D; i++) begin
            mem[i]  = '0;
            pend[i] = 1'b0;
        end
    endtask

    task automatic check_ports(input string tag);
        check({tag, "_data_a"}, rd_data_a, exp_data(int'(rd_addr_a)));
        check({tag, "_data_b"}, rd_data_b, exp_data(int'(rd_addr_b)));
        check({tag, "_busy_a"}, W'(busy_a), W'(exp_busy(int'(rd_addr_a))));
        check({tag, "_busy_b"}, W'(busy_b), W'(exp_busy(int'(rd_addr_b))));
    endtask

    // Advance one edge, then update the model from the inputs that edge sampled.
    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            if (wr_en && int'(wr_addr) != Z) begin
                mem[wr_addr]  = wr_data;
                pend[wr_addr] = 1'b0;
            end
            if (issue_en && int'(issue_addr) != Z) pend[issue_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic drive(input logic we, input int wa, input logic [W-1:0] wd,
                         input logic ie, input int ia, input int ra, input int rb);
        wr_en      = we;
        wr_addr    = AW'(wa);
        wr_data    = wd;
        issue_en   = ie;
        issue_addr = AW'(ia);
        rd_addr_a  = AW'(ra);
        rd_addr_b  = AW'(rb);
    endtask

    function automatic int pick();
        int r = $urandom_range(0, 9);
        if (r == 0) return Z;
        if (r < 7) return $urandom_range(0, 7);
        return $urandom_range(0, D - 1);
    endfunction

    initial begin
        model_clear();
        reset = 1'b1;
        drive(0, 0, '0, 0, 0, 0, 0);
        #12;
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int a = 0; a < D; a++) begin
            drive(0, 0, '0, 0, 0, a, D - 1 - a);
            #1;
            check("rst_data_a", rd_data_a, '0);
            check("rst_busy_a", W'(busy_a), '0);
        end

        drive(1, 5, 64'hDEAD_BEEF_0123_4567, 0, 0, 5, 5);
        #1;
        check("byp5_a", rd_data_a, 64'hDEAD_BEEF_0123_4567);
        tick();
        drive(0, 0, '0, 0, 0, 5, 0);
        #1;
        check("stor5_a", rd_data_a, 64'hDEAD_BEEF_0123_4567);

        drive(1, Z, '1, 0, 0, Z, Z);
        #1;
        check("z_pre_a", rd_data_a, '0);
        check("z_pre_b", rd_data_b, '0);
        tick();
        drive(0, 0, '0, 0, 0, Z, Z);
        #1;
        check("z_post_a", rd_data_a, '0);
        check("z_post_busy", W'(busy_b), '0);

        drive(0, 0, '0, 1, 7, 7, 0);
        tick();
        drive(0, 0, '0, 0, 0, 7, 0);
        #1;
        check("iss7_busy", W'(busy_a), 1);
        drive(1, 7, 64'h77, 0, 0, 7, 7);
        #1;
        check("wb7_busy", W'(busy_a), 0);
        tick();
        drive(0, 0, '0, 0, 0, 7, 7);
        #1;
        check("wb7_after", W'(busy_a), 0);
        check("wb7_data", rd_data_b, 64'h77);

        drive(1, 9, 64'h42, 1, 9, 0, 0);
        tick();
        drive(0, 0, '0, 0, 0, 9, 9);
        #1;
        check("same9_data", rd_data_a, 64'h42);
        check("same9_busy", W'(busy_b), 1);

        drive(1, 3, 64'h3333, 1, 3, 0, 0);
        tick();
        drive(1, 4, 64'h4444, 1, 4, 0, 0);
        tick();
        drive(0, 0, '0, 0, 0, 3, 4);
        #1;
        check("pre_rst_busy3", W'(busy_a), 1);
        check("pre_rst_data4", rd_data_b, 64'h4444);
        #1;
        reset = 1'b1;
        model_clear();
        #1;
        check("async_data3", rd_data_a, '0);
        check("async_busy3", W'(busy_a), '0);
        check("async_data4", rd_data_b, '0);
        check("async_busy4", W'(busy_b), '0);
        drive(1, 6, 64'h66, 1, 6, 6, 4);
        #1;
        check("rst_bypass6", rd_data_a, 64'h66);
        tick();
        drive(0, 0, '0, 0, 0, 6, 6);
        #1;
        check("rst_ignored_wr", rd_data_a, '0);
        check("rst_ignored_iss", W'(busy_b), '0);
        reset = 1'b0;
        drive(0, 0, '0, 1, 2, 2, 2);
        tick();
        drive(0, 0, '0, 0, 0, 2, 2);
        #1;
        check("post_rst_iss", W'(busy_a), 1);

        for (int n = 0; n < 600; n++) begin
            logic [W-1:0] d;
            d = {$urandom, $urandom};
            drive(($urandom_range(0, 2) != 0), pick(), d,
                  ($urandom_range(0, 2) == 0), pick(), pick(), pick());
            #1;
            check_ports("rnd");
            if ($urandom_range(0, 59) == 0) begin
                #1;
                reset = 1'b1;
                model_clear();
                #1;
                check_ports("rnd_rst");
                tick();
                reset = 1'b0;
            end else begin
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file_nbit.md
REGISTER_FILE_NBIT -- requirements
Module: register_file_nbit

Interface
REQ-001 SHALL have parameter WIDTH, default 64, data bits per register.
REQ-002 SHALL have parameter DEPTH, default 32, number of registers; AW = clog2(DEPTH).
REQ-003 SHALL have parameter ZERO_REG, default 31, index of the hardwired-zero register.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port rd_addr_a / rd_addr_b  input  AW  read-port A/B address.
REQ-007 SHALL have port rd_data_a / rd_data_b  output  WIDTH  read-port A/B data.
REQ-008 SHALL have port busy_a / busy_b  output  1  pending-write flag of the addressed register.
REQ-009 SHALL have port wr_en  input  1  writeback strobe.
REQ-010 SHALL have port wr_addr  input  AW  writeback register index.
REQ-011 SHALL have port wr_data  input  WIDTH  writeback data.
REQ-012 SHALL have port issue_en  input  1  marks a register as awaiting a writeback.
REQ-013 SHALL have port issue_addr  input  AW  register being claimed.

Function
REQ-014 Storage SHALL be DEPTH x WIDTH flops; register wr_addr SHALL load wr_data on the clk edge where wr_en=1.
REQ-015 Reads SHALL be combinational, zero latency.
REQ-016 Write bypass: when wr_en=1 and rd_addr_x == wr_addr (not ZERO_REG), rd_data_x SHALL equal wr_data in the same cycle.
REQ-017 ZERO_REG SHALL always read 0; writes to it SHALL be ignored; issue to it SHALL be ignored.
REQ-018 Addresses >= DEPTH SHALL read 0 with busy 0; writes/issues to them SHALL be ignored.
REQ-019 Scoreboard: one pending bit per register; issue_en=1 SHALL set pending[issue_addr] at the next edge.
REQ-020 wr_en=1 SHALL clear pending[wr_addr] at the next edge.
REQ-021 Same-cycle issue and write to the same address SHALL leave pending set (the new claim wins); data SHALL still be written.
REQ-022 Same-cycle issue and write to different addresses SHALL apply both.
REQ-023 busy_x SHALL equal pending[rd_addr_x], except 0 when wr_en=1 and wr_addr == rd_addr_x with no same-cycle issue to that address (bypass clears busy).
REQ-024 Writes to a non-pending register SHALL be accepted (pending stays 0).
REQ-025 Ports A and B SHALL be fully independent; identical addresses SHALL return identical results.

Reset
REQ-026 Asserting reset SHALL immediately, without waiting for clk, force all registers to 0 and all pending bits to 0.
REQ-027 While reset=1, wr_en and issue_en SHALL have no effect; outputs SHALL read 0 data and busy 0, except bypassed wr_data per REQ-016 (combinational path is not gated).
REQ-028 Reset asserted mid-operation SHALL discard any outstanding pending claims; first post-reset edge SHALL behave as normal operation.

Structure
REQ-029 A shared package SHALL hold default WIDTH, DEPTH, ZERO_REG and the register-index type.
REQ-030 One sub-module, regfile_entry (WIDTH-bit register with load enable and async reset), SHALL be instantiated DEPTH times via generate; the scoreboard and read muxes SHALL live in the top.

Verification
REQ-031 Reset then read all addresses -> every rd_data 0, every busy 0.
REQ-032 Write 0xDEAD_BEEF_0123_4567 to reg 5 with rd_addr_a=5 same cycle -> rd_data_a bypasses that value; next cycle reads it from storage.
REQ-033 Write 0xFFFF_FFFF_FFFF_FFFF to reg 31 -> rd_data 0 on both ports, busy 0, before and after the edge.
REQ-034 Issue reg 7; next cycle busy_a=1 (rd_addr_a=7); write reg 7 -> busy_a=0 same cycle, pending 0 after edge.
REQ-035 Same cycle issue reg 9 and write reg 9 = 0x42 -> after edge rd_data=0x42 and busy=1.
REQ-036 Pending on regs 3,4 with data loaded; assert reset between edges -> data and busy drop to 0 immediately.
